// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a 2x2 weight-stationary systolic array: diagonal weight load,
// skewed activation streaming and bottom-edge de-skew into whole result rows.
module systolic_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int ROWS_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_start,
  input  logic [ROWS_W-1:0] cmd_n_rows,
  input  logic [DATA_W-1:0] w_00,
  input  logic [DATA_W-1:0] w_01,
  input  logic [DATA_W-1:0] w_10,
  input  logic [DATA_W-1:0] w_11,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic              err_skew,
  input  logic              act_valid,
  output logic              act_ready,
  input  logic [DATA_W-1:0] act_x0,
  input  logic [DATA_W-1:0] act_x1,
  output logic [DATA_W-1:0] sys_data_in_1x,
  output logic [DATA_W-1:0] sys_data_in_2x,
  output logic              sys_start,
  output logic [DATA_W-1:0] sys_weight_in_x1,
  output logic [DATA_W-1:0] sys_weight_in_x2,
  output logic              sys_accept_w_1,
  output logic              sys_accept_w_2,
  output logic              sys_switch_in,
  input  logic [DATA_W-1:0] sys_data_out_x1,
  input  logic [DATA_W-1:0] sys_data_out_x2,
  input  logic              sys_valid_out_x1,
  input  logic              sys_valid_out_x2,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_y0,
  output logic [DATA_W-1:0] res_y1
);

  // state  | meaning
  // IDLE   | waiting for cmd_start
  // L0     | shift W[1][0] into column 1
  // L1     | shift W[0][0] into column 1, W[1][1] into column 2
  // L2     | shift W[0][1] into column 2, switch weight bank
  // STREAM | accept activation rows, drive skewed left edge
  // DRAIN  | wait for remaining result rows
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_L0, S_L1, S_L2, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  localparam logic [ROWS_W-1:0] ROW_ONE = ROWS_W'(1);

  state_t state, state_nx;

  logic [DATA_W-1:0] w00_q, w01_q, w10_q, w11_q;
  logic [ROWS_W-1:0] n_rows_q;
  logic [ROWS_W-1:0] rows_in;
  logic [ROWS_W-1:0] rows_out;
  logic [DATA_W-1:0] skew_q;
  logic [DATA_W-1:0] x1_hold;
  logic              prev_v1;

  logic              accept;
  logic              hs;
  logic              deskew_on;
  logic              res_take;
  logic              last_in;
  logic              rows_done;

  logic              acc1_nx, acc2_nx, sw_nx;
  logic [DATA_W-1:0] wx1_nx, wx2_nx;

  assign accept    = (state == S_IDLE) && cmd_start;
  assign act_ready = (state == S_STREAM) && (rows_in < n_rows_q);
  assign hs        = act_valid && act_ready;
  assign deskew_on = (state == S_STREAM) || (state == S_DRAIN);
  assign res_take  = deskew_on && sys_valid_out_x2;
  assign last_in   = (rows_in + ROW_ONE) == n_rows_q;
  assign rows_done = (rows_out == n_rows_q) ||
                     (res_take && ((rows_out + ROW_ONE) == n_rows_q));

  assign cmd_busy  = (state != S_IDLE);
  assign cmd_done  = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (accept) state_nx = S_L0;
      S_L0:     state_nx = S_L1;
      S_L1:     state_nx = S_L2;
      S_L2:     state_nx = (n_rows_q != '0) ? S_STREAM : S_DONE;
      S_STREAM: if (hs && last_in) state_nx = S_DRAIN;
      S_DRAIN:  if (rows_done) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Weight-port values are decoded from the next state so they appear
  // registered in the matching load cycle; L0 is entered straight from
  // IDLE, before W is latched, so it reads the command port directly.
  always_comb begin
    acc1_nx = 1'b0;
    acc2_nx = 1'b0;
    sw_nx   = 1'b0;
    wx1_nx  = '0;
    wx2_nx  = '0;
    case (state_nx)
      S_L0: begin
        acc1_nx = 1'b1;
        wx1_nx  = w_10;
      end
      S_L1: begin
        acc1_nx = 1'b1;
        wx1_nx  = w00_q;
        acc2_nx = 1'b1;
        wx2_nx  = w11_q;
      end
      S_L2: begin
        acc2_nx = 1'b1;
        wx2_nx  = w01_q;
        sw_nx   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_accept_w_1   <= 1'b0;
      sys_accept_w_2   <= 1'b0;
      sys_switch_in    <= 1'b0;
      sys_weight_in_x1 <= '0;
      sys_weight_in_x2 <= '0;
    end else begin
      sys_accept_w_1   <= acc1_nx;
      sys_accept_w_2   <= acc2_nx;
      sys_switch_in    <= sw_nx;
      sys_weight_in_x1 <= wx1_nx;
      sys_weight_in_x2 <= wx2_nx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w00_q    <= '0;
      w01_q    <= '0;
      w10_q    <= '0;
      w11_q    <= '0;
      n_rows_q <= '0;
    end else if (accept) begin
      w00_q    <= w_00;
      w01_q    <= w_01;
      w10_q    <= w_10;
      w11_q    <= w_11;
      n_rows_q <= cmd_n_rows;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows_in  <= '0;
      rows_out <= '0;
    end else if (accept) begin
      rows_in  <= '0;
      rows_out <= '0;
    end else begin
      if (hs)       rows_in  <= rows_in + ROW_ONE;
      if (res_take) rows_out <= rows_out + ROW_ONE;
    end
  end

  // Lane 2 trails lane 1 by one cycle; bubbles propagate through the skew stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sys_data_in_1x <= '0;
      sys_start      <= 1'b0;
      skew_q         <= '0;
      sys_data_in_2x <= '0;
    end else begin
      sys_data_in_1x <= hs ? act_x0 : '0;
      sys_start      <= hs;
      skew_q         <= hs ? act_x1 : '0;
      sys_data_in_2x <= skew_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_hold   <= '0;
      prev_v1   <= 1'b0;
      res_valid <= 1'b0;
      res_y0    <= '0;
      res_y1    <= '0;
      err_skew  <= 1'b0;
    end else begin
      if (deskew_on && sys_valid_out_x1) x1_hold <= sys_data_out_x1;
      prev_v1   <= deskew_on && sys_valid_out_x1;
      res_valid <= res_take;
      if (res_take) begin
        res_y0 <= x1_hold;
        res_y1 <= sys_data_out_x2;
      end
      // Row is still emitted on a skew error; the flag only records it.
      if (accept)                   err_skew <= 1'b0;
      else if (res_take && !prev_v1) err_skew <= 1'b1;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: behavioural 2x2 array model, result scoreboard
// and weight-load/reset/skew-error scenarios.
module tb_systolic_seq_ctrl;
  localparam int DW = 16;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_start = 1'b0;
  logic [RW-1:0] cmd_n_rows = '0;
  logic [DW-1:0] w_00 = '0, w_01 = '0, w_10 = '0, w_11 = '0;
  logic          cmd_busy, cmd_done, err_skew;
  logic          act_valid = 1'b0;
  logic          act_ready;
  logic [DW-1:0] act_x0 = '0, act_x1 = '0;
  logic [DW-1:0] sys_data_in_1x, sys_data_in_2x;
  logic          sys_start;
  logic [DW-1:0] sys_weight_in_x1, sys_weight_in_x2;
  logic          sys_accept_w_1, sys_accept_w_2, sys_switch_in;
  logic [DW-1:0] sys_data_out_x1 = '0, sys_data_out_x2 = '0;
  logic          sys_valid_out_x1 = 1'b0, sys_valid_out_x2 = 1'b0;
  logic          res_valid;
  logic [DW-1:0] res_y0, res_y1;

  always #5 clk = ~clk;

  systolic_seq_ctrl #(.DATA_W(DW), .ROWS_W(RW)) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_n_rows(cmd_n_rows),
    .w_00(w_00), .w_01(w_01), .w_10(w_10), .w_11(w_11),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .err_skew(err_skew),
    .act_valid(act_valid), .act_ready(act_ready),
    .act_x0(act_x0), .act_x1(act_x1),
    .sys_data_in_1x(sys_data_in_1x), .sys_data_in_2x(sys_data_in_2x),
    .sys_start(sys_start),
    .sys_weight_in_x1(sys_weight_in_x1), .sys_weight_in_x2(sys_weight_in_x2),
    .sys_accept_w_1(sys_accept_w_1), .sys_accept_w_2(sys_accept_w_2),
    .sys_switch_in(sys_switch_in),
    .sys_data_out_x1(sys_data_out_x1), .sys_data_out_x2(sys_data_out_x2),
    .sys_valid_out_x1(sys_valid_out_x1), .sys_valid_out_x2(sys_valid_out_x2),
    .res_valid(res_valid), .res_y0(res_y0), .res_y1(res_y1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic [15:0] q_mac(input logic [15:0] a0, input logic [15:0] b0,
                                        input logic [15:0] a1, input logic [15:0] b1);
    logic signed [31:0] s;
    s = $signed(a0) * $signed(b0) + $signed(a1) * $signed(b1);
    return s[23:8];
  endfunction

  // scoreboard (written by stimulus, read by monitor)
  logic [15:0] exp_y0 [64];
  logic [15:0] exp_y1 [64];
  bit          exp_chk0 [64];
  int          exp_wr = 0, exp_rd = 0;
  logic [15:0] ln_x0 [64];
  logic [15:0] ln_x1 [64];
  int          ln_wr = 0, ln_rd0 = 0, ln_rd1 = 0;
  int          drop_req = 0, drop_ack = 0;

  // array model state
  logic [15:0] c1_top, c1_bot, c2_top, c2_bot, aw00, aw01, aw10, aw11;
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [15:0] p1_a0, p2_y1, my0, my1;

  always @(negedge clk) begin
    if (!rst) begin
      p1_v = 1'b0; p2_v = 1'b0;
      sys_valid_out_x1 = 1'b0; sys_valid_out_x2 = 1'b0;
      sys_data_out_x1 = '0; sys_data_out_x2 = '0;
      exp_rd = exp_wr; ln_rd0 = ln_wr; ln_rd1 = ln_wr;
    end else begin
      if (res_valid) begin
        check_val("res_pending", 32'(exp_rd < exp_wr), 1);
        if (exp_rd < exp_wr) begin
          if (exp_chk0[exp_rd]) check_val("res_y0", res_y0, exp_y0[exp_rd]);
          check_val("res_y1", res_y1, exp_y1[exp_rd]);
          exp_rd++;
        end
      end
      if (sys_accept_w_1) begin c1_bot = c1_top; c1_top = sys_weight_in_x1; end
      if (sys_accept_w_2) begin c2_bot = c2_top; c2_top = sys_weight_in_x2; end
      if (sys_switch_in) begin
        aw00 = c1_top; aw10 = c1_bot; aw01 = c2_top; aw11 = c2_bot;
      end
      sys_valid_out_x2 = p2_v;
      sys_data_out_x2  = p2_v ? p2_y1 : '0;
      p2_v = 1'b0;
      if (p1_v) begin
        check_val("lane2_skew", sys_data_in_2x, ln_x1[ln_rd1]);
        ln_rd1++;
        my0 = q_mac(p1_a0, aw00, sys_data_in_2x, aw10);
        my1 = q_mac(p1_a0, aw01, sys_data_in_2x, aw11);
        if (drop_req != drop_ack) begin
          drop_ack = drop_req;
          sys_valid_out_x1 = 1'b0; sys_data_out_x1 = '0;
        end else begin
          sys_valid_out_x1 = 1'b1; sys_data_out_x1 = my0;
        end
        p2_v = 1'b1; p2_y1 = my1;
      end else begin
        sys_valid_out_x1 = 1'b0; sys_data_out_x1 = '0;
      end
      if (sys_start) begin
        check_val("lane1_data", sys_data_in_1x, ln_x0[ln_rd0]);
        ln_rd0++;
      end else if (cmd_busy) begin
        check_val("bubble_1x", sys_data_in_1x, 0);
      end
      p1_v  = sys_start;
      p1_a0 = sys_data_in_1x;
    end
  end

  logic [15:0] rx0 [8];
  logic [15:0] rx1 [8];

  task automatic push_row(input int idx, input logic [15:0] a00, input logic [15:0] a01,
                          input logic [15:0] a10, input logic [15:0] a11, input bit chk0);
    exp_y0[exp_wr]   = q_mac(rx0[idx], a00, rx1[idx], a10);
    exp_y1[exp_wr]   = q_mac(rx0[idx], a01, rx1[idx], a11);
    exp_chk0[exp_wr] = chk0;
    exp_wr++;
    ln_x0[ln_wr] = rx0[idx];
    ln_x1[ln_wr] = rx1[idx];
    ln_wr++;
  endtask

  task automatic run_op(input logic [15:0] a00, input logic [15:0] a01,
                        input logic [15:0] a10, input logic [15:0] a11,
                        input int n, input bit toggle, input bit busy_pulse,
                        input bit err_mode, input bit exp_err);
    int idx, cyc, done_cnt;
    bit v;
    @(negedge clk);
    check_val("idle_busy", cmd_busy, 0);
    w_00 = a00; w_01 = a01; w_10 = a10; w_11 = a11;
    cmd_n_rows = n[RW-1:0];
    cmd_start = 1'b1;
    if (err_mode) drop_req = drop_req + 1;
    @(negedge clk);
    cmd_start = 1'b0;
    w_00 = 16'hdead; w_01 = 16'hdead; w_10 = 16'hdead; w_11 = 16'hdead;
    check_val("l0_flags", {sys_accept_w_1, sys_accept_w_2, sys_switch_in}, 3'b100);
    check_val("l0_x1", sys_weight_in_x1, a10);
    check_val("l0_x2", sys_weight_in_x2, 0);
    check_val("l0_busy_err_rdy", {cmd_busy, err_skew, act_ready}, 3'b100);
    @(negedge clk);
    check_val("l1_flags", {sys_accept_w_1, sys_accept_w_2, sys_switch_in}, 3'b110);
    check_val("l1_x1", sys_weight_in_x1, a00);
    check_val("l1_x2", sys_weight_in_x2, a11);
    @(negedge clk);
    check_val("l2_flags", {sys_accept_w_1, sys_accept_w_2, sys_switch_in}, 3'b011);
    check_val("l2_x1", sys_weight_in_x1, 0);
    check_val("l2_x2", sys_weight_in_x2, a01);
    check_val("l2_rdy", act_ready, 0);
    @(negedge clk);
    if (n == 0) check_val("n0_done_rdy", {cmd_done, act_ready}, 2'b10);
    idx = 0; cyc = 0;
    while (idx < n && cyc < 200) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      act_valid = v; act_x0 = rx0[idx]; act_x1 = rx1[idx];
      if (busy_pulse) begin
        cmd_start  = (cyc == 1);
        cmd_n_rows = 5'd9;
      end
      if (v && act_ready) begin
        push_row(idx, a00, a01, a10, a11, !(err_mode && idx == 0));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    act_valid = 1'b0; cmd_start = 1'b0;
    check_val("rows_sent", idx, n);
    done_cnt = 0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_done) done_cnt++;
      else if (done_cnt > 0) break;
      @(negedge clk);
    end
    check_val("done_pulses", done_cnt, 1);
    check_val("busy_after_done", cmd_busy, 0);
    check_val("results_drained", exp_wr - exp_rd, 0);
    check_val("err_skew", err_skew, exp_err);
  endtask

  initial begin
    #1;
    check_val("rst_ctrl0", {act_ready, cmd_busy, cmd_done, err_skew, sys_start,
                            sys_accept_w_1, sys_accept_w_2, sys_switch_in, res_valid}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // identity weights
    rx0[0] = 16'h0100; rx1[0] = 16'h0200;
    rx0[1] = 16'h0500; rx1[1] = 16'h0600;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 2, 0, 0, 0, 0);

    // W = [[1,2],[3,4]] raw words
    rx0[0] = 16'h0100; rx1[0] = 16'h0200;
    run_op(16'd1, 16'd2, 16'd3, 16'd4, 1, 0, 0, 0, 0);

    // bubbled valid plus an ignored cmd_start while busy
    rx0[0] = 16'h0300; rx1[0] = 16'h0180;
    rx0[1] = 16'hff00; rx1[1] = 16'h0040;
    run_op(16'h0100, 16'h0100, 16'h0000, 16'h0100, 2, 1, 1, 0, 0);

    // zero rows
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 0, 0, 0, 0, 0);

    // reset in mid-STREAM
    @(negedge clk);
    w_00 = 16'h0100; w_01 = 16'h0000; w_10 = 16'h0000; w_11 = 16'h0100;
    cmd_n_rows = 5'd3; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    repeat (3) @(negedge clk);
    rx0[0] = 16'h0300; rx1[0] = 16'h0400;
    act_valid = 1'b1; act_x0 = rx0[0]; act_x1 = rx1[0];
    check_val("rst_pre_ready", act_ready, 1);
    push_row(0, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 1);
    @(negedge clk);
    act_valid = 1'b0;
    check_val("rst_pre_start", {cmd_busy, sys_start}, 2'b11);
    #2 rst = 1'b0;
    #1;
    check_val("rst_ctrl", {act_ready, cmd_busy, cmd_done, err_skew, sys_start,
                           sys_accept_w_1, sys_accept_w_2, sys_switch_in, res_valid}, 0);
    check_val("rst_data", sys_data_in_1x | sys_data_in_2x | sys_weight_in_x1 |
                          sys_weight_in_x2 | res_y0 | res_y1, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    rx0[0] = 16'h0700; rx1[0] = 16'h0800;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 1, 0, 0, 0, 0);

    // array drops valid_out_x1 on the first row -> sticky skew error
    rx0[0] = 16'h0100; rx1[0] = 16'h0200;
    rx0[1] = 16'h0900; rx1[1] = 16'h0a00;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 2, 0, 0, 1, 1);
    repeat (3) @(negedge clk);
    check_val("err_sticky", err_skew, 1);
    rx0[0] = 16'h0200; rx1[0] = 16'h0300;
    run_op(16'h0100, 16'h0000, 16'h0000, 16'h0100, 1, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencer for the 2x2 weight-stationary systolic array.
- On a command, it latches a 2x2 weight matrix W and runs the 3-cycle diagonal weight-load/switch sequence.
- It then streams N activation rows into the left edge with the lane-2 skew applied.
- It de-skews the bottom-edge outputs into whole result rows (Y = A x W) and signals completion.
- It sits between the host/buffer logic and the systolic array. All data is Q8.8 fixed16.

Parameters:
DATA_W, 16, width of every data/weight word (Q8.8)
ROWS_W, 5, width of row count; max rows = 2**ROWS_W - 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
cmd_start  in  1  start pulse; sampled only in IDLE
cmd_n_rows  in  ROWS_W  number of activation rows; sampled with cmd_start
w_00, w_01, w_10, w_11  in  DATA_W each  W[row][col]; sampled with cmd_start
cmd_busy  out  1  high from cycle after accepted cmd_start through DONE
cmd_done  out  1  one-cycle pulse in DONE
err_skew  out  1  sticky de-skew error; cleared on accepted cmd_start
act_valid  in  1  activation row valid
act_ready  out  1  controller accepts row
act_x0, act_x1  in  DATA_W  row elements A[r][0], A[r][1]
sys_data_in_1x, sys_data_in_2x  out  DATA_W  array left-edge data, lanes 1/2
sys_start  out  1  valid accompanying sys_data_in_1x
sys_weight_in_x1, sys_weight_in_x2  out  DATA_W  array top-edge weights, columns 1/2
sys_accept_w_1, sys_accept_w_2  out  1  weight shift enables, columns 1/2
sys_switch_in  out  1  weight bank switch
sys_data_out_x1, sys_data_out_x2  in  DATA_W  array bottom outputs
sys_valid_out_x1, sys_valid_out_x2  in  1  array bottom valids
res_valid  out  1  result row valid (no backpressure)
res_y0, res_y1  out  DATA_W  result row Y[r][0], Y[r][1]

Behaviour:

Reset (rst low, async):
- State = IDLE; all counters cleared.
- Every output = 0, including act_ready, cmd_busy and err_skew.
- Reset mid-operation aborts the operation with no cmd_done.

States: IDLE -> L0 -> L1 -> L2 -> STREAM -> DRAIN -> DONE -> IDLE.

IDLE:
- cmd_start latches W and n_rows and clears err_skew.
- Next state is L0.
- cmd_start in any other state is ignored.

Weight load (all outputs registered; values not listed are 0):
- L0: accept_w_1=1, weight_in_x1=W[1][0].
- L1: accept_w_1=1, weight_in_x1=W[0][0]; accept_w_2=1, weight_in_x2=W[1][1].
- L2: accept_w_2=1, weight_in_x2=W[0][1]; switch_in=1.
- From L2: go to STREAM if n_rows>0, else go to DONE.

STREAM:
- act_ready=1 while rows_in < n_rows.
- On a handshake: sys_data_in_1x=act_x0 and sys_start=1 in the following cycle; act_x1 is held in a skew register and drives sys_data_in_2x one cycle after that.
- A cycle with no handshake drives sys_data_in_1x=0 and sys_start=0 (bubble). The skew register follows the same rule.
- After the n_rows-th handshake: act_ready drops in the next cycle and the state moves to DRAIN.

DRAIN:
- Lane-2 skew flushes naturally; left-edge outputs otherwise hold 0.
- Leave DRAIN when rows_out == n_rows.

Output de-skew (active in STREAM and DRAIN):
- sys_data_out_x1 is registered whenever sys_valid_out_x1=1.
- When sys_valid_out_x2=1: res_valid=1 (registered, next cycle), res_y0 = registered x1 word, res_y1 = sys_data_out_x2; rows_out increments.
- err_skew sets if sys_valid_out_x2=1 without sys_valid_out_x1=1 in the previous cycle. The row is still emitted.

DONE:
- Lasts one cycle: cmd_done=1, cmd_busy=1.
- Then IDLE, with cmd_busy=0.

Arithmetic and sizing:
- No arithmetic is performed; data passes through unmodified.
- rows_in and rows_out are ROWS_W bits wide and cannot wrap, because n_rows <= 2**ROWS_W - 1.

Simultaneous events:
- res_valid may coincide with an input handshake; both are serviced.
- The final result row and the DRAIN->DONE transition happen in the same cycle as the last res_valid is registered. cmd_done follows one cycle later.

Test Plan:
- Identity W (0x0100, 0, 0, 0x0100), n_rows=2, rows (0x0100, 0x0200), (0x0500, 0x0600) -> res rows (0x0100, 0x0200), (0x0500, 0x0600) in order; cmd_done once; err_skew=0.
- W = [[1,2],[3,4]] -> L0/L1/L2 outputs: x1 = 3, then 1; x2 = 4 (L1), then 2 (L2); accept_w_1 high in L0 and L1; accept_w_2 high in L1 and L2; switch_in high only in L2.
- act_valid toggled 1,0,1,0 over 2 rows -> sys_start shows a bubble; sys_data_in_2x lags 1x by exactly one cycle; results still correct.
- n_rows=0 -> L0-L2 run, act_ready never high, cmd_done pulses in the cycle after L2.
- Assert rst low in mid-STREAM -> all outputs 0 in the same cycle; a new cmd_start after release works normally. A cmd_start while busy is ignored.
- Array model asserts valid_out_x2 with no prior valid_out_x1 -> err_skew=1 and stays high until the next cmd_start.
